// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the M-stage load/store unit.
// Op codes, FSM encoding, exception codes and small decode helpers.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        EXC_NONE    = 2'd0,
        EXC_ADDR    = 2'd1,
        EXC_TIMEOUT = 2'd2
    } excp_e;

    localparam logic [31:0] PC_PLUS8 = 32'd8;

    // Undefined op codes behave as a bubble in the memory path.
    function automatic mem_op_e decode_op(input logic [3:0] code);
        return (code <= 4'd8) ? mem_op_e'(code) : OP_NONE;
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic misaligned(input mem_op_e op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return |lo;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane logic: store byte enables / data replication and
// load byte/halfword extraction with sign or zero extension.
module mem_stage_align
    import mem_stage_pkg::*;
(
    input  mem_op_e     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign rhalf = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = st_data_i;
        case (op_i)
            OP_SB: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            OP_SH: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{st_data_i[15:0]}};
            end
            OP_SW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

    always_comb begin
        load_o = '0;
        case (op_i)
            OP_LB:   load_o = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  load_o = {24'd0, rbyte};
            OP_LH:   load_o = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  load_o = {16'd0, rhalf};
            OP_LW:   load_o = rdata_i;
            default: load_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// M pipeline stage with a single-outstanding load/store bus FSM and timeout.
// MEM_STAGE_LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of masking.
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ins_in,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       alu_result_in,
    input  logic [31:0]       rt_data_in,
    input  logic [3:0]        mem_op_in,
    input  logic              valid_in,
    input  logic              flush_in,
    input  logic [31:0]       grf_data_in,
    input  logic              rt_fwd_sel,
    output logic [31:0]       ins_w,
    output logic [31:0]       pc_w,
    output logic [31:0]       alu_result_m,
    output logic [31:0]       pc_m_plus8,
    output logic [31:0]       load_data_out,
    output logic              valid_w,
    output logic              stall_out,
    output logic [1:0]        excp_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [31:0]       ins_q, pc_q, alu_q, rt_q, rdata_q;
    mem_op_e           op_q;
    logic              valid_q;
    lsu_state_e        state_q;
    logic [15:0]       cnt_q;
    excp_e             excp_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;

    logic              mem_active, addr_err, load_d;
    logic [31:0]       st_data_d, wdata_d, load_ext;
    logic [3:0]        be_d;

    assign mem_active = valid_q && (op_q != OP_NONE);
    assign st_data_d  = rt_fwd_sel ? grf_data_in : rt_q;

`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
    assign addr_err = mem_active && misaligned(op_q, alu_q[1:0]);
`else
    assign addr_err = 1'b0;
`endif

    mem_stage_align u_align (
        .op_i      (op_q),
        .addr_lo_i (alu_q[1:0]),
        .st_data_i (st_data_d),
        .rdata_i   (rdata_q),
        .be_o      (be_d),
        .wdata_o   (wdata_d),
        .load_o    (load_ext)
    );

    // M register freezes while the bus access is outstanding, so a flush
    // arriving mid-stall only takes effect on the next accepted edge.
    assign load_d = valid_in && !flush_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ins_q   <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            rt_q    <= '0;
            op_q    <= OP_NONE;
            valid_q <= 1'b0;
        end else if (!stall_out) begin
            ins_q   <= ins_in;
            pc_q    <= pc_in;
            alu_q   <= alu_result_in;
            rt_q    <= rt_data_in;
            op_q    <= load_d ? decode_op(mem_op_in) : OP_NONE;
            valid_q <= load_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            excp_q      <= EXC_NONE;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_active && !addr_err) begin
                        state_q     <= ST_REQ;
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_store(op_q);
                        mem_addr_q  <= ADDR_W'(alu_q) & ~ADDR_W'(3);
                        mem_be_q    <= be_d;
                        mem_wdata_q <= wdata_d;
                    end
                end
                ST_REQ: begin
                    // An ack on the final allowed cycle still counts as success.
                    if (mem_ack) begin
                        state_q   <= ST_DONE;
                        mem_req_q <= 1'b0;
                        rdata_q   <= mem_rdata;
                        excp_q    <= EXC_NONE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= ST_DONE;
                        mem_req_q <= 1'b0;
                        rdata_q   <= '0;
                        excp_q    <= EXC_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    excp_q  <= EXC_NONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall_out     = mem_active && (state_q != ST_DONE) && !addr_err;
    assign excp_out      = addr_err ? EXC_ADDR : ((state_q == ST_DONE) ? excp_q : EXC_NONE);
    assign valid_w       = valid_q && ((op_q == OP_NONE) || (state_q == ST_DONE) || (excp_out != 2'd0));
    assign load_data_out = ((state_q == ST_DONE) && (excp_q == EXC_NONE)) ? load_ext : '0;

    assign ins_w        = ins_q;
    assign pc_w         = pc_q;
    assign alu_result_m = alu_q;
    assign pc_m_plus8   = pc_q + PC_PLUS8;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed cases plus random traffic,
// with a memory responder that decides ack timing per request.
module tb_mem_stage_lsu;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ins_in, pc_in, alu_result_in, rt_data_in, grf_data_in;
    logic [3:0]  mem_op_in;
    logic        valid_in, flush_in, rt_fwd_sel;
    logic [31:0] ins_w, pc_w, alu_result_m, pc_m_plus8, load_data_out;
    logic        valid_w, stall_out;
    logic [1:0]  excp_out;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    mem_stage_lsu #(.ADDR_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .ins_in        (ins_in),
        .pc_in         (pc_in),
        .alu_result_in (alu_result_in),
        .rt_data_in    (rt_data_in),
        .mem_op_in     (mem_op_in),
        .valid_in      (valid_in),
        .flush_in      (flush_in),
        .grf_data_in   (grf_data_in),
        .rt_fwd_sel    (rt_fwd_sel),
        .ins_w         (ins_w),
        .pc_w          (pc_w),
        .alu_result_m  (alu_result_m),
        .pc_m_plus8    (pc_m_plus8),
        .load_data_out (load_data_out),
        .valid_w       (valid_w),
        .stall_out     (stall_out),
        .excp_out      (excp_out),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins, pc, alu, rt, grf, rdata;
        logic        fwd, valid, flush;
        logic [3:0]  op;
        int          ack_cycle;
    } stim_t;

    typedef struct {
        logic [31:0] ins, pc, alu, pc8, load;
        logic [1:0]  excp;
        int          stall;
    } exp_t;

    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
        logic        we;
        int          ack_cycle;
    } req_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    req_t  mreq_q[$];

    int n_checks = 0;
    int n_errors = 0;
    logic sb_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: byte lanes computed arithmetically from the address.
    function automatic logic [31:0] model_load(input int op, input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * (addr % 4))) & 32'hFF;
        h = (rd >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (op)
            1: return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            2: return b;
            3: return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            4: return h;
            5: return rd;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input int op, input logic [31:0] addr);
        case (op)
            6: return 4'(32'd1 << (addr % 4));
            7: return (((addr / 2) % 2) != 0) ? 4'd12 : 4'd3;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input int op, input logic [31:0] d);
        case (op)
            6: return (d & 32'hFF) * 32'h0101_0101;
            7: return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic model_misaligned(input int op, input logic [31:0] addr);
        if (op == 3 || op == 4 || op == 7) return (addr % 2) != 0;
        if (op == 5 || op == 8) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    task automatic push_expect(input stim_t s);
        exp_t e;
        req_t r;
        int   op;
        logic trap;
        if (!s.valid || s.flush) return;
        op = (s.op > 4'd8) ? 0 : int'(s.op);
        e.ins = s.ins; e.pc = s.pc; e.alu = s.alu; e.pc8 = s.pc + 32'd8;
        e.load = 32'd0; e.excp = 2'd0; e.stall = 0;
`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
        trap = model_misaligned(op, s.alu);
`else
        trap = 1'b0;
`endif
        if (op != 0 && trap) begin
            e.excp = 2'd1;
        end else if (op != 0) begin
            r.addr      = s.alu & 32'hFFFF_FFFC;
            r.be        = model_be(op, s.alu);
            r.wdata     = model_wdata(op, s.fwd ? s.grf : s.rt);
            r.we        = (op >= 6);
            r.rdata     = s.rdata;
            r.ack_cycle = s.ack_cycle;
            mreq_q.push_back(r);
            if (s.ack_cycle <= TB_TIMEOUT) begin
                e.load  = model_load(op, s.alu, s.rdata);
                e.stall = 1 + s.ack_cycle;
            end else begin
                e.excp  = 2'd2;
                e.stall = 1 + TB_TIMEOUT;
            end
        end
        exp_q.push_back(e);
    endtask

    function automatic stim_t mk(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] rt,
                                 input logic [31:0] grf, input logic fwd, input logic [31:0] rdata,
                                 input int ack_cycle);
        stim_t s;
        s.ins = $urandom; s.pc = $urandom & 32'hFFFF_FFFC;
        s.op = op; s.alu = alu; s.rt = rt; s.grf = grf; s.fwd = fwd; s.rdata = rdata;
        s.ack_cycle = ack_cycle; s.valid = 1'b1; s.flush = 1'b0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        ins_in = s.ins; pc_in = s.pc; alu_result_in = s.alu; rt_data_in = s.rt;
        mem_op_in = s.op; valid_in = s.valid; flush_in = s.flush;
        grf_data_in = s.grf; rt_fwd_sel = s.fwd;
    endtask

    // Stall-time noise: must not reach the frozen M register.
    task automatic drive_junk();
        ins_in = $urandom; pc_in = $urandom; alu_result_in = $urandom; rt_data_in = $urandom;
        mem_op_in = 4'($urandom_range(0, 15));
        valid_in = 1'($urandom_range(0, 1));
        flush_in = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_bubble();
        valid_in = 1'b0; flush_in = 1'b0; mem_op_in = 4'd0;
    endtask

    int stall_run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (sb_en && !reset) begin
            if (stall_out) stall_run++;
            if (valid_w) begin
                if (exp_q.size() == 0) begin
                    check("valid_w_without_expect", 32'(valid_w), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ins_w", ins_w, e.ins);
                    check("pc_w", pc_w, e.pc);
                    check("alu_result_m", alu_result_m, e.alu);
                    check("pc_m_plus8", pc_m_plus8, e.pc8);
                    check("load_data_out", load_data_out, e.load);
                    check("excp_out", 32'(excp_out), 32'(e.excp));
                    check("stall_cycles", 32'(stall_run), 32'(e.stall));
                end
                stall_run = 0;
            end
        end else begin
            stall_run = 0;
        end
    end

    logic prev_req = 1'b0;
    int   req_cnt = 0;
    req_t cur;
    always @(negedge clk) begin
        if (!sb_en || reset) begin
            mem_ack = 1'b0;
            prev_req = 1'b0;
        end else if (mem_req) begin
            if (!prev_req) begin
                req_cnt = 1;
                if (mreq_q.size() == 0) begin
                    check("req_without_expect", 32'(mem_req), 32'd0);
                    cur.addr = mem_addr; cur.be = mem_be; cur.wdata = mem_wdata;
                    cur.we = mem_we; cur.rdata = 32'd0; cur.ack_cycle = 1;
                end else begin
                    cur = mreq_q.pop_front();
                end
            end else begin
                req_cnt++;
            end
            check("mem_addr", mem_addr, cur.addr);
            check("mem_be", 32'(mem_be), 32'(cur.be));
            check("mem_wdata", mem_wdata, cur.wdata);
            check("mem_we", 32'(mem_we), 32'(cur.we));
            mem_ack = (req_cnt == cur.ack_cycle);
            mem_rdata = mem_ack ? cur.rdata : $urandom;
            prev_req = 1'b1;
        end else begin
            mem_ack = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
            prev_req = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        int    cyc;
        logic  drained;

        reset = 1'b1;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        drive(mk(4'd5, 32'h0000_0103, 32'h1111_2222, 32'h3333_4444, 1'b1, 32'd0, 1));

        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_stall_out", 32'(stall_out), 32'd0);
        check("rst_valid_w", 32'(valid_w), 32'd0);
        @(posedge clk); #1;
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_excp_out", 32'(excp_out), 32'd0);
        check("rst_pc_m_plus8", pc_m_plus8, 32'd8);
        check("rst_load_data", load_data_out, 32'd0);
        check("rst_ins_w", ins_w, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);

        @(negedge clk);
        drive_bubble();
        reset = 1'b0;
        sb_en = 1'b1;

        stim_q.push_back(mk(4'd8, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 2));
        stim_q.push_back(mk(4'd1, 32'h0000_0203, 32'h0, 32'h0, 1'b0, 32'h80FF_FFFF, 1));
        stim_q.push_back(mk(4'd2, 32'h0000_0203, 32'h0, 32'h0, 1'b0, 32'h80FF_FFFF, 3));
        stim_q.push_back(mk(4'd7, 32'h0000_0012, 32'h0000_ABCD, 32'h0000_1234, 1'b1, 32'h0, 1));
        stim_q.push_back(mk(4'd5, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 32'h1234_5678, 7));
        stim_q.push_back(mk(4'd5, 32'h0000_0102, 32'h0, 32'h0, 1'b0, 32'hCAFE_F00D, 1));
        stim_q.push_back(mk(4'd3, 32'h0000_2002, 32'h0, 32'h0, 1'b0, 32'h8001_7FFF, 4));
        stim_q.push_back(mk(4'd4, 32'h0000_2000, 32'h0, 32'h0, 1'b0, 32'h1234_F00D, 2));
        stim_q.push_back(mk(4'd6, 32'h0000_0301, 32'h0000_005A, 32'h0, 1'b0, 32'h0, 1));
        s = mk(4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1);
        s.pc = 32'hFFFF_FFFC;
        stim_q.push_back(s);
        stim_q.push_back(mk(4'd12, 32'h0000_0444, 32'h0, 32'h0, 1'b0, 32'h0, 1));
        s = mk(4'd8, 32'h0000_0500, 32'h0, 32'h0, 1'b0, 32'h0, 1);
        s.flush = 1'b1;
        stim_q.push_back(s);

        for (int i = 0; i < 300; i++) begin
            s = mk(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
                   1'($urandom_range(0, 1)), $urandom, int'($urandom_range(1, 6)));
            if ($urandom_range(0, 1) == 0) s.alu = s.alu & 32'hFFFF_FFFC;
            s.pc    = $urandom;
            s.valid = ($urandom_range(0, 9) != 0);
            s.flush = ($urandom_range(0, 9) == 0);
            stim_q.push_back(s);
        end

        cyc = 0;
        while (stim_q.size() > 0 && cyc < 30000) begin
            @(negedge clk); #1;
            cyc++;
            if (!stall_out) begin
                s = stim_q.pop_front();
                push_expect(s);
                drive(s);
            end else begin
                drive_junk();
            end
        end
        check("stim_consumed", 32'(stim_q.size()), 32'd0);

        drained = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (!stall_out) drive_bubble(); else drive_junk();
            if (exp_q.size() == 0 && !stall_out) begin
                drained = 1'b1;
                break;
            end
        end
        check("drain", 32'(drained), 32'd1);
        check("mreq_drained", 32'(mreq_q.size()), 32'd0);

        sb_en = 1'b0;
        @(negedge clk); #1;
        drive(mk(4'd5, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 32'h0, 1));
        @(negedge clk); #1;
        drive_bubble();
        @(posedge clk); #2;
        check("req_before_reset", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_mem_req", 32'(mem_req), 32'd0);
        check("async_rst_valid_w", 32'(valid_w), 32'd0);
        check("async_rst_stall", 32'(stall_out), 32'd0);
        check("async_rst_pc8", pc_m_plus8, 32'd8);
        check("async_rst_be", 32'(mem_be), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_mem_req", 32'(mem_req), 32'd0);
        check("post_rst_valid_w", 32'(valid_w), 32'd0);
        check("post_rst_stall", 32'(stall_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
